// File: rtl/mem_rr_arbiter_if.sv
// Native-interface request bus: N request lanes sharing one response path.
// The arbiter is the slave on the core side and the master downstream.
interface mem_rr_arbiter_if #(
  parameter int N  = 1,
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic [N-1:0]    valid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*SW-1:0] wstrb;
  logic [N-1:0]    ready;
  logic [DW-1:0]   rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Shares one downstream memory port among N native-interface masters,
// one transaction in flight, with round-robin or fixed priority and a timeout.
module mem_rr_arbiter #(
  parameter int N_PORTS        = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       resetn,
  mem_rr_arbiter_if.slave            up,
  mem_rr_arbiter_if.master           dn,
  output logic [$clog2(N_PORTS)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_pulse
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_PORTS);
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ?
                          $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_dn_valid;
  logic [ADDR_W-1:0]   r_dn_addr;
  logic [DATA_W-1:0]   r_dn_wdata;
  logic [STRB_W-1:0]   r_dn_wstrb;
  logic [N_PORTS-1:0]  r_up_ready;
  logic [DATA_W-1:0]   r_up_rdata;
  logic                r_busy;
  logic                r_err;

  logic                w_found;
  logic [IDX_W-1:0]    w_win;
  int                  w_base;
  int                  w_idx;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_timeout;
  logic [N_PORTS-1:0]  w_gnt_oh;

  assign w_base = (PRIO_MODE != 0) ? 0 : int'(r_rr_ptr);

  // Scan downward so the last hit is the first index in scan order.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      w_idx = w_base + i;
      if (w_idx >= N_PORTS) w_idx = w_idx - N_PORTS;
      if (up.valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(w_idx);
      end
    end
  end

  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                     (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES));
  assign w_gnt_oh  = {{(N_PORTS-1){1'b0}}, 1'b1} << r_grant;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_dn_valid <= 1'b0;
      r_dn_addr  <= '0;
      r_dn_wdata <= '0;
      r_dn_wstrb <= '0;
      r_up_ready <= '0;
      r_up_rdata <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_dn_valid <= 1'b1;
            r_dn_addr  <= up.addr[int'(w_win)*ADDR_W +: ADDR_W];
            r_dn_wdata <= up.wdata[int'(w_win)*DATA_W +: DATA_W];
            r_dn_wstrb <= up.wstrb[int'(w_win)*STRB_W +: STRB_W];
            r_grant    <= w_win;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A completion in the expiring cycle still beats the abort.
          if (dn.ready[0]) begin
            r_dn_valid <= 1'b0;
            r_up_rdata <= (r_dn_wstrb == '0) ? dn.rdata : '0;
            r_up_ready <= w_gnt_oh;
            r_state    <= S_RESP;
          end else if (w_timeout) begin
            r_dn_valid <= 1'b0;
            r_up_rdata <= '1;
            r_up_ready <= w_gnt_oh;
            r_err      <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_RESP: begin
          r_up_ready <= '0;
          r_err      <= 1'b0;
          r_busy     <= 1'b0;
          if (PRIO_MODE == 0) begin
            r_rr_ptr <= (r_grant == IDX_W'(N_PORTS - 1)) ?
                        '0 : r_grant + 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dn.valid  = r_dn_valid;
  assign dn.addr   = r_dn_addr;
  assign dn.wdata  = r_dn_wdata;
  assign dn.wstrb  = r_dn_wstrb;
  assign up.ready  = r_up_ready;
  assign up.rdata  = r_up_rdata;
  assign grant_id  = r_grant;
  assign busy      = r_busy;
  assign err_pulse = r_err;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: one round-robin and one
// fixed-priority instance, both with an 8-cycle timeout.
module tb_mem_rr_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  bit           sel;
  logic [3:0]   tb_valid;
  logic [127:0] tb_addr;
  logic [127:0] tb_wdata;
  logic [15:0]  tb_wstrb;
  logic         tb_ready;
  logic [31:0]  tb_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  mem_rr_arbiter_if #(.N(4), .AW(32), .DW(32)) rr_up ();
  mem_rr_arbiter_if #(.N(1), .AW(32), .DW(32)) rr_dn ();
  mem_rr_arbiter_if #(.N(4), .AW(32), .DW(32)) fp_up ();
  mem_rr_arbiter_if #(.N(1), .AW(32), .DW(32)) fp_dn ();

  logic [1:0] rr_gid, fp_gid;
  logic       rr_busy, fp_busy, rr_err, fp_err;

  mem_rr_arbiter #(
    .N_PORTS(4), .ADDR_W(32), .DATA_W(32),
    .PRIO_MODE(0), .TIMEOUT_CYCLES(8)
  ) u_rr (
    .clk(clk), .resetn(resetn),
    .up(rr_up), .dn(rr_dn),
    .grant_id(rr_gid), .busy(rr_busy), .err_pulse(rr_err)
  );

  mem_rr_arbiter #(
    .N_PORTS(4), .ADDR_W(32), .DATA_W(32),
    .PRIO_MODE(1), .TIMEOUT_CYCLES(8)
  ) u_fp (
    .clk(clk), .resetn(resetn),
    .up(fp_up), .dn(fp_dn),
    .grant_id(fp_gid), .busy(fp_busy), .err_pulse(fp_err)
  );

  assign rr_up.valid = sel ? 4'b0 : tb_valid;
  assign fp_up.valid = sel ? tb_valid : 4'b0;
  assign rr_up.addr  = tb_addr;
  assign fp_up.addr  = tb_addr;
  assign rr_up.wdata = tb_wdata;
  assign fp_up.wdata = tb_wdata;
  assign rr_up.wstrb = tb_wstrb;
  assign fp_up.wstrb = tb_wstrb;
  assign rr_dn.ready = !sel && tb_ready;
  assign fp_dn.ready = sel && tb_ready;
  assign rr_dn.rdata = tb_rdata;
  assign fp_dn.rdata = tb_rdata;

  logic        obs_dn_valid;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_wstrb, obs_up_ready;
  logic [1:0]  obs_gid;
  logic        obs_busy, obs_err;

  assign obs_dn_valid = sel ? fp_dn.valid[0] : rr_dn.valid[0];
  assign obs_addr     = sel ? fp_dn.addr     : rr_dn.addr;
  assign obs_wdata    = sel ? fp_dn.wdata    : rr_dn.wdata;
  assign obs_wstrb    = sel ? fp_dn.wstrb    : rr_dn.wstrb;
  assign obs_rdata    = sel ? fp_up.rdata    : rr_up.rdata;
  assign obs_up_ready = sel ? fp_up.ready    : rr_up.ready;
  assign obs_gid      = sel ? fp_gid         : rr_gid;
  assign obs_busy     = sel ? fp_busy        : rr_busy;
  assign obs_err      = sel ? fp_err         : rr_err;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_port(input int k, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    tb_addr[k*32 +: 32]  = a;
    tb_wdata[k*32 +: 32] = d;
    tb_wstrb[k*4 +: 4]   = s;
  endtask

  // Called at a negedge; waits for the grant, answers after
  // wait_cyc cycles, checks the response and returns in IDLE.
  task automatic serve(input int wait_cyc, input logic [31:0] data,
                       input int exp_g, input logic [31:0] exp_addr,
                       input logic [31:0] exp_rd, input string tag);
    int n = 0;
    while (!obs_dn_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " dn_valid"}, 32'(obs_dn_valid), 32'd1);
    chk({tag, " grant"}, 32'(obs_gid), 32'(exp_g));
    chk({tag, " addr"}, obs_addr, exp_addr);
    repeat (wait_cyc) @(negedge clk);
    tb_ready = 1'b1;
    tb_rdata = data;
    @(negedge clk);
    tb_ready = 1'b0;
    chk({tag, " up_ready"}, 32'(obs_up_ready), 32'(4'b1 << exp_g));
    chk({tag, " rdata"}, obs_rdata, exp_rd);
    chk({tag, " err"}, 32'(obs_err), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sel = 1'b0;
    tb_valid = '0;
    tb_addr = '0;
    tb_wdata = '0;
    tb_wstrb = '0;
    tb_ready = 1'b0;
    tb_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst dn_valid", 32'(obs_dn_valid), 32'd0);
    chk("rst busy", 32'(obs_busy), 32'd0);
    chk("rst grant", 32'(obs_gid), 32'd0);
    chk("rst up_ready", 32'(obs_up_ready), 32'd0);
    chk("rst err", 32'(obs_err), 32'd0);
    chk("rst rdata", obs_rdata, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Single master, slave answers one cycle after dn_valid.
    set_port(2, 32'h0000_0040, 32'h0, 4'h0);
    tb_valid = 4'b0100;
    @(negedge clk);
    chk("t1 dn_valid", 32'(obs_dn_valid), 32'd1);
    chk("t1 grant", 32'(obs_gid), 32'd2);
    chk("t1 addr", obs_addr, 32'h40);
    chk("t1 busy", 32'(obs_busy), 32'd1);
    @(negedge clk);
    chk("t1 early ready", 32'(obs_up_ready), 32'd0);
    tb_ready = 1'b1;
    tb_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    tb_ready = 1'b0;
    tb_valid = 4'b0;
    chk("t1 up_ready", 32'(obs_up_ready), 32'b0100);
    chk("t1 rdata", obs_rdata, 32'hDEAD_BEEF);
    chk("t1 dn_drop", 32'(obs_dn_valid), 32'd0);
    @(negedge clk);
    chk("t1 ready pulse", 32'(obs_up_ready), 32'd0);
    chk("t1 idle busy", 32'(obs_busy), 32'd0);

    // Round-robin from a fresh pointer with all masters valid.
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) set_port(k, 32'h100 + 32'(4*k), 32'h0, 4'h0);
    tb_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      serve(0, 32'hA000_0000 + 32'(i), i % 4, 32'h100 + 32'(4*(i % 4)),
            32'hA000_0000 + 32'(i), "rr");
    end
    tb_valid = 4'h0;

    // Dead slave: abort after 8 ISSUE cycles.
    set_port(0, 32'h200, 32'h0, 4'h0);
    tb_valid = 4'b0001;
    n = 0;
    @(negedge clk);
    chk("to grant", 32'(obs_gid), 32'd0);
    while (obs_dn_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    tb_valid = 4'b0;
    chk("to issue cycles", 32'(n), 32'd8);
    chk("to up_ready", 32'(obs_up_ready), 32'b0001);
    chk("to rdata", obs_rdata, 32'hFFFF_FFFF);
    chk("to err", 32'(obs_err), 32'd1);
    tb_ready = 1'b1;
    tb_rdata = 32'h1234_0000;
    @(negedge clk);
    tb_ready = 1'b0;
    chk("to err pulse", 32'(obs_err), 32'd0);
    chk("to ready pulse", 32'(obs_up_ready), 32'd0);
    @(negedge clk);
    chk("late ready dn", 32'(obs_dn_valid), 32'd0);
    chk("late ready up", 32'(obs_up_ready), 32'd0);
    chk("late ready busy", 32'(obs_busy), 32'd0);

    // Completion on the 8th ISSUE cycle wins over the timeout.
    tb_valid = 4'b0001;
    serve(7, 32'h1234_5678, 0, 32'h200, 32'h1234_5678, "race");
    tb_valid = 4'b0;

    // Writes return zero; a new request must not disturb dn_*.
    set_port(2, 32'h300, 32'hCAFE_F00D, 4'hF);
    set_port(0, 32'h304, 32'h1111_1111, 4'h1);
    tb_valid = 4'b0100;
    @(negedge clk);
    chk("wr wstrb", 32'(obs_wstrb), 32'hF);
    chk("wr wdata", obs_wdata, 32'hCAFE_F00D);
    tb_valid = 4'b0101;
    @(negedge clk);
    chk("stab addr", obs_addr, 32'h300);
    chk("stab grant", 32'(obs_gid), 32'd2);
    chk("stab wdata", obs_wdata, 32'hCAFE_F00D);
    serve(0, 32'h5555_5555, 2, 32'h300, 32'h0, "wr2");
    tb_valid = 4'b0001;
    serve(0, 32'h6666_6666, 0, 32'h304, 32'h0, "wr0");
    chk("wr0 wstrb", 32'(obs_wstrb), 32'h1);
    tb_valid = 4'b0;

    // Asynchronous reset in the middle of a write.
    set_port(3, 32'h400, 32'hA5A5_A5A5, 4'b0011);
    tb_valid = 4'b1000;
    @(negedge clk);
    chk("ar grant", 32'(obs_gid), 32'd3);
    chk("ar wstrb", 32'(obs_wstrb), 32'b0011);
    #2 resetn = 1'b0;
    #1;
    chk("ar dn_valid", 32'(obs_dn_valid), 32'd0);
    chk("ar wstrb0", 32'(obs_wstrb), 32'd0);
    chk("ar addr0", obs_addr, 32'd0);
    chk("ar busy", 32'(obs_busy), 32'd0);
    chk("ar grant0", 32'(obs_gid), 32'd0);
    @(negedge clk);
    set_port(0, 32'h500, 32'h0, 4'h0);
    tb_valid = 4'b1001;
    resetn = 1'b1;
    serve(0, 32'h0000_0077, 0, 32'h500, 32'h77, "post rst");
    tb_valid = 4'b0;

    // Fixed priority: port 1 starves port 3 while valid.
    sel = 1'b1;
    set_port(1, 32'h600, 32'h0, 4'h0);
    set_port(3, 32'h604, 32'h0, 4'h0);
    tb_valid = 4'b1010;
    #1;
    for (int i = 0; i < 3; i++) begin
      serve(0, 32'hB0 + 32'(i), 1, 32'h600, 32'hB0 + 32'(i), "fp1");
    end
    tb_valid = 4'b1000;
    serve(0, 32'hC0, 3, 32'h604, 32'hC0, "fp3");
    tb_valid = 4'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
